// File: rtl/wrr_pkg.sv
// Shared types and helpers for the weighted round-robin arbiter.
package wrr_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

    // A programmed weight of zero still earns a single beat.
    function automatic logic [15:0] eff_weight(input logic [15:0] w);
        if (w == 16'd0) begin
            return 16'd1;
        end else begin
            return w;
        end
    endfunction

endpackage

// File: rtl/wrr_arbiter_rr_pick.sv
// Cyclic first-set picker: finds the first request at or above ptr, wrapping.
module rr_pick #(
    parameter int N = 8,
    parameter int M = $clog2(N)
) (
    input  logic [N-1:0] req_i,
    input  logic [M-1:0] ptr_i,
    output logic [N-1:0] onehot_o,
    output logic [M-1:0] idx_o,
    output logic         any_o
);

    logic [N-1:0] rot_s;
    logic [N-1:0] iso_s;

    // Rotate so ptr lands at bit 0, keep the lowest set bit, rotate back.
    assign rot_s    = N'({req_i, req_i} >> ptr_i);
    assign iso_s    = rot_s & (~rot_s + N'(1));
    assign onehot_o = N'(({iso_s, iso_s} << ptr_i) >> N);
    assign any_o    = |req_i;

    // One-hot to binary index encoder.
    always_comb begin
        idx_o = '0;
        for (int i = 0; i < N; i++) begin
            idx_o = idx_o | (onehot_o[i] ? M'(i) : M'(0));
        end
    end

endmodule

// File: rtl/wrr_arbiter.sv
// Weighted round-robin arbiter: bursts of up to weight[i] acknowledged beats,
// priority rotating to the index after each burst winner.
module wrr_arbiter
    import wrr_pkg::*;
#(
    parameter int N  = 8,
    parameter int WW = 4
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic [N-1:0]      i_req,
    input  logic [N*WW-1:0]   i_weight,
    input  logic              i_ack,
    output logic              o_valid,
    output logic [N-1:0]      o_gnt,
    output logic [$clog2(N)-1:0] o_gnt_idx,
    output logic              o_last
);

    localparam int M = $clog2(N);

    state_e          state_q, state_d;
    logic [M-1:0]    ptr_q, ptr_d;
    logic [WW-1:0]   credit_q, credit_d;
    logic [N-1:0]    gnt_q, gnt_d;
    logic [M-1:0]    idx_q, idx_d;
    logic            valid_q, valid_d;
    logic            last_q, last_d;

    logic [WW-1:0]   weight_s [N];
    logic [M-1:0]    ptr_inc_s;
    logic [M-1:0]    pick_ptr_s;
    logic [N-1:0]    pick_onehot_s;
    logic [M-1:0]    pick_idx_s;
    logic            pick_any_s;
    logic [WW-1:0]   eff_w_s;
    logic            req_w_s;
    logic            burst_end_s;
    logic            load_s;
    logic            clear_s;

    for (genvar g = 0; g < N; g++) begin : g_weight
        assign weight_s[g] = i_weight[g*WW +: WW];
    end

    // In GRANT the picker only matters at burst end, where priority starts after the winner.
    assign ptr_inc_s   = (idx_q == M'(N-1)) ? M'(0) : idx_q + M'(1);
    assign pick_ptr_s  = (state_q == ST_GRANT) ? ptr_inc_s : ptr_q;
    assign eff_w_s     = WW'(eff_weight(16'(weight_s[pick_idx_s])));
    assign req_w_s     = i_req[idx_q];
    assign burst_end_s = (state_q == ST_GRANT) &&
                         (!req_w_s || (i_ack && (credit_q == WW'(1))));

    rr_pick #(.N(N), .M(M)) u_pick (
        .req_i    (i_req),
        .ptr_i    (pick_ptr_s),
        .onehot_o (pick_onehot_s),
        .idx_o    (pick_idx_s),
        .any_o    (pick_any_s)
    );

    // State, pointer, credit and registered outputs.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q  <= ST_IDLE;
            ptr_q    <= '0;
            credit_q <= '0;
            gnt_q    <= '0;
            idx_q    <= '0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            credit_q <= credit_d;
            gnt_q    <= gnt_d;
            idx_q    <= idx_d;
            valid_q  <= valid_d;
            last_q   <= last_d;
        end
    end

    // Next state, pointer and credit; flags burst loads and grant clears.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        credit_d = credit_q;
        load_s   = 1'b0;
        clear_s  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pick_any_s) begin
                    state_d  = ST_GRANT;
                    credit_d = eff_w_s;
                    load_s   = 1'b1;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (burst_end_s) begin
                    ptr_d = ptr_inc_s;
                    if (pick_any_s) begin
                        state_d  = ST_GRANT;
                        credit_d = eff_w_s;
                        load_s   = 1'b1;
                    end else begin
                        state_d  = ST_IDLE;
                        credit_d = '0;
                        clear_s  = 1'b1;
                    end
                end else if (i_ack) begin
                    credit_d = credit_q - WW'(1);
                end else begin
                    credit_d = credit_q;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                credit_d = '0;
                clear_s  = 1'b1;
            end
        endcase
    end

    // Next values of the registered grant outputs; o_last tracks next credit.
    always_comb begin
        gnt_d   = gnt_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        last_d  = last_q;
        if (load_s) begin
            gnt_d   = pick_onehot_s;
            idx_d   = pick_idx_s;
            valid_d = 1'b1;
            last_d  = (eff_w_s == WW'(1));
        end else if (clear_s) begin
            gnt_d   = '0;
            idx_d   = '0;
            valid_d = 1'b0;
            last_d  = 1'b0;
        end else begin
            last_d  = valid_q && (credit_d == WW'(1));
        end
    end

    assign o_valid   = valid_q;
    assign o_gnt     = gnt_q;
    assign o_gnt_idx = idx_q;
    assign o_last    = last_q;

endmodule

// File: tb/tb_wrr_arbiter.sv
// Self-checking bench for wrr_arbiter (N=4): directed scenarios plus random traffic
// compared against a burst-level reference model.
module tb_wrr_arbiter;

    localparam int N  = 4;
    localparam int WW = 4;
    localparam int M  = 2;

    logic              i_clk = 1'b0;
    logic              i_rstn;
    logic [N-1:0]      i_req;
    logic [N*WW-1:0]   i_weight;
    logic              i_ack;
    logic              o_valid;
    logic [N-1:0]      o_gnt;
    logic [M-1:0]      o_gnt_idx;
    logic              o_last;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: current burst owner, remaining beats, rotation start.
    int m_valid;
    int m_idx;
    int m_credit;
    int m_ptr;

    wrr_arbiter #(.N(N), .WW(WW)) dut (
        .i_clk     (i_clk),
        .i_rstn    (i_rstn),
        .i_req     (i_req),
        .i_weight  (i_weight),
        .i_ack     (i_ack),
        .o_valid   (o_valid),
        .o_gnt     (o_gnt),
        .o_gnt_idx (o_gnt_idx),
        .o_last    (o_last)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int wfield(input int i);
        return int'(i_weight[i*WW +: WW]);
    endfunction

    function automatic int pick(input logic [N-1:0] req, input int from);
        for (int k = 0; k < N; k++) begin
            if (req[(from + k) % N]) return (from + k) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_valid  = 0;
        m_idx    = 0;
        m_credit = 0;
        m_ptr    = 0;
    endtask

    task automatic model_load(input int w);
        m_valid  = 1;
        m_idx    = w;
        m_credit = (wfield(w) == 0) ? 1 : wfield(w);
    endtask

    task automatic model_step();
        int w;
        if (m_valid == 0) begin
            w = pick(i_req, m_ptr);
            if (w >= 0) model_load(w);
        end else if (!i_req[m_idx] || (i_ack && m_credit == 1)) begin
            m_ptr = (m_idx + 1) % N;
            w = pick(i_req, m_ptr);
            if (w >= 0) model_load(w);
            else begin
                m_valid  = 0;
                m_idx    = 0;
                m_credit = 0;
            end
        end else if (i_ack) begin
            m_credit = m_credit - 1;
        end
    endtask

    task automatic check_outputs(input string tag);
        logic [31:0] exp_gnt;
        exp_gnt = (m_valid != 0) ? (32'd1 << m_idx) : 32'd0;
        check({tag, "_valid"}, 32'(o_valid), 32'(m_valid));
        check({tag, "_gnt"}, 32'(o_gnt), exp_gnt);
        check({tag, "_idx"}, 32'(o_gnt_idx), (m_valid != 0) ? 32'(m_idx) : 32'd0);
        check({tag, "_last"}, 32'(o_last), 32'((m_valid != 0) && (m_credit == 1)));
    endtask

    task automatic step(input string tag);
        @(posedge i_clk);
        model_step();
        #1;
        check_outputs(tag);
    endtask

    task automatic do_reset();
        i_rstn = 1'b0;
        i_req  = '0;
        i_ack  = 1'b0;
        model_reset();
        @(posedge i_clk);
        #1;
        check_outputs("reset");
        i_rstn = 1'b1;
    endtask

    initial begin
        int exp1 [5];
        int exp2 [8];
        int lst2 [8];
        exp1 = '{0, 1, 2, 3, 0};
        exp2 = '{0, 0, 0, 1, 2, 2, 3, 0};
        lst2 = '{0, 0, 1, 1, 0, 1, 1, 0};
        i_weight = '0;
        do_reset();

        // All weights 1, everyone requesting: plain rotation.
        i_weight = 16'h1111;
        i_req = 4'b1111;
        i_ack = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step("t1");
            check("t1_seq_idx", 32'(o_gnt_idx), 32'(exp1[k]));
            check("t1_seq_last", 32'(o_last), 32'd1);
        end

        // Weights {3,1,2,1}.
        do_reset();
        i_weight = 16'h1213;
        i_req = 4'b1111;
        i_ack = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step("t2");
            check("t2_seq_idx", 32'(o_gnt_idx), 32'(exp2[k]));
            check("t2_seq_last", 32'(o_last), 32'(lst2[k]));
        end

        // Single requester, weight 5, toggling ack.
        do_reset();
        i_weight = 16'h0500;
        i_req = 4'b0100;
        for (int k = 0; k < 14; k++) begin
            i_ack = k[0];
            step("t3");
            check("t3_held", 32'(o_gnt), 32'h4);
        end

        // Withdrawal mid-burst moves the grant on from ptr=2.
        do_reset();
        i_weight = 16'h0040;
        i_req = 4'b0010;
        step("t4");
        i_ack = 1'b1;
        step("t4");
        step("t4");
        i_req = 4'b1001;
        i_ack = 1'b0;
        step("t4");
        check("t4_next_idx", 32'(o_gnt_idx), 32'd3);
        i_req = 4'b0000;
        step("t4");
        check("t4_idle", 32'(o_valid), 32'd0);

        // Zero weight on idx3 with pointer wrap.
        do_reset();
        i_weight = 16'h0000;
        i_req = 4'b0100;
        step("t5");
        i_req = 4'b1001;
        step("t5");
        check("t5_idx3", 32'(o_gnt_idx), 32'd3);
        check("t5_last3", 32'(o_last), 32'd1);
        i_ack = 1'b1;
        step("t5");
        check("t5_wrap_idx0", 32'(o_gnt_idx), 32'd0);

        // Asynchronous reset in the middle of a burst.
        do_reset();
        i_weight = 16'h0003;
        i_req = 4'b0001;
        step("t6");
        i_ack = 1'b1;
        step("t6");
        i_rstn = 1'b0;
        model_reset();
        #1;
        check_outputs("t6_async");
        #2;
        i_rstn = 1'b1;
        i_ack = 1'b0;
        i_req = 4'b0100;
        step("t6");
        check("t6_restart_idx", 32'(o_gnt_idx), 32'd2);

        // Random traffic against the model.
        do_reset();
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 9) == 0) i_weight = 16'($urandom);
            i_req = ($urandom_range(0, 3) == 0) ? 4'($urandom) : (i_req | 4'($urandom_range(0, 1) << $urandom_range(0, 3)));
            if ($urandom_range(0, 7) == 0) i_req = i_req & 4'($urandom);
            i_ack = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 149) == 0) begin
                do_reset();
            end else begin
                step("rand");
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/wrr_arbiter.md
Name: wrr_arbiter

Overview:
Weighted round-robin arbiter with per-requester programmable burst weights and a grant/acknowledge handshake. The winning requester keeps the grant for up to weight[i] consecutive acknowledged beats. Priority then rotates to the index after the winner. It sits in front of shared resources (bus, memory port) where requesters need unequal bandwidth shares. It supersedes the plain and modified round-robin arbiters in the same family.

Parameters:
N, 8, number of requesters (any value >= 2, power of two not required)
WW, 4, width of each weight field; max burst = 2^WW-1 beats
M, $clog2(N) (localparam), width of index/pointer

Ports:
i_clk  input  1  clock
i_rstn  input  1  reset, asynchronous, active-low
i_req  input  N  request vector, level-sensitive
i_weight  input  N*WW  flattened weights; requester i uses bits [i*WW +: WW]
i_ack  input  1  consumer accepts current grant beat
o_valid  output  1  a grant is active
o_gnt  output  N  one-hot grant (all zero when o_valid=0)
o_gnt_idx  output  M  binary index of granted requester (0 when idle)
o_last  output  1  current beat is the final beat of the burst (remaining credit == 1)

Behaviour:
- Reset (async, i_rstn=0): state=IDLE, ptr=0, credit=0, o_valid=0, o_gnt=0, o_gnt_idx=0, o_last=0. Reset mid-burst aborts the burst immediately with no pending state.
- All outputs are registered. Grant appears 1 cycle after request is sampled in IDLE.
- Pick function: winner = first index w with i_req[w]=1, searching cyclically from ptr upward (ptr, ptr+1, ..., N-1, 0, ...).
- Effective weight: eff_w(i) = i_weight field i, with 0 treated as 1. Weight is sampled only at burst start; later changes do not affect the running burst.
- States: IDLE, GRANT.
- IDLE: if |i_req, then load w, credit<=eff_w(w), o_gnt<=onehot(w), o_gnt_idx<=w, o_valid<=1, go to GRANT. Otherwise stay.
- GRANT, i_ack=1 and i_req[w]=1 and credit>1: credit<=credit-1, grant unchanged (next beat of the same burst).
- GRANT, burst end. Trigger: i_ack=1 with credit==1, or i_ack=1 with i_req[w]=0, or i_req[w]=0 without ack (withdrawal revokes the grant). Action:
  - ptr<=(w+1) mod N, wrapping N-1 to 0.
  - Re-arbitrate in the same cycle using ptr'=(w+1) mod N and the current i_req with bit w masked if it is 0.
  - If there is a winner: load the new burst (back-to-back, no bubble) and stay in GRANT.
  - Otherwise: clear outputs and go to IDLE.
  - If w is the only requester, w wins a fresh burst.
- GRANT, i_ack=0 and i_req[w]=1: hold all outputs and credit.
- o_last = o_valid & (credit==1), registered consistently with credit.
- i_ack while o_valid=0 is ignored.
- Invariants: o_gnt is one-hot or zero; o_gnt[o_gnt_idx]==o_valid; o_gnt is a subset of the i_req sampled at burst load.
- Starvation bound: every continuously requesting i is granted within sum over j≠i of eff_w(j) acknowledged beats plus N cycles.

Decomposition:
- Shared package wrr_pkg holds the state enum typedef (IDLE, GRANT) and the eff_weight function (0 maps to 1).
- One combinational sub-module rr_pick(N): inputs req and ptr; outputs onehot, idx, any. Implemented as rotate-right, isolate lowest set bit, rotate-left. Instantiated once and shared by the IDLE and burst-end paths.

Test Plan:
1. N=4, all weights=1, i_req=4'b1111, i_ack=1 constant → o_gnt_idx sequence 0,1,2,3,0 on consecutive cycles; o_last=1 every beat.
2. N=4, weights {3,1,2,1} (idx0..3), all requesting, ack every cycle → indices 0,0,0,1,2,2,3,0, ...; o_last high on beats 3,4,6,7.
3. Req idx2 only, weight 5, i_ack toggled 1-0-1-0 → grant held through ack=0 cycles; burst ends after 5 acks, then idx2 gets a new burst immediately.
4. Idx1 granted with weight 4, i_req[1] drops after 2 acks → next cycle grant moves to next requester from ptr=2; o_valid stays 1 if others request, else 0.
5. Weight field 0 on idx3, wrap: ptr=3, i_req=4'b1001 → idx3 gets exactly 1 beat, then ptr wraps to 0 and idx0 wins.
6. Assert i_rstn=0 mid-burst (credit=2) → all outputs 0 asynchronously; after release with i_req=4'b0100, grant idx2 one cycle later (ptr restarted at 0).
